// File: rtl/rvfpm_result_buffer.sv
// In-order result FIFO between the FPU model's XIF result interface and the core;
// discards killed results. Define RVFPM_RESBUF_BYPASS_EN for zero-latency empty-buffer bypass.
module rvfpm_result_buffer #(
   parameter int DEPTH      = 4,
   parameter int X_ID_WIDTH = 4,
   parameter int FLEN       = 32
) (
   input  logic                         ck,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [X_ID_WIDTH-1:0]        in_id,
   input  logic [FLEN-1:0]              in_data,
   input  logic [4:0]                   in_rd,
   input  logic [2:0]                   in_ecswe,
   input  logic [5:0]                   in_ecsdata,
   input  logic                         commit_valid,
   input  logic [X_ID_WIDTH-1:0]        commit_id,
   input  logic                         commit_kill,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [X_ID_WIDTH-1:0]        out_id,
   output logic [FLEN-1:0]              out_data,
   output logic [4:0]                   out_rd,
   output logic [2:0]                   out_ecswe,
   output logic [5:0]                   out_ecsdata,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         drop
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [X_ID_WIDTH-1:0] id_q      [DEPTH];
   logic [FLEN-1:0]       data_q    [DEPTH];
   logic [4:0]            rd_q      [DEPTH];
   logic [2:0]            ecswe_q   [DEPTH];
   logic [5:0]            ecsdata_q [DEPTH];
   logic [DEPTH-1:0]      valid_q;
   logic [DEPTH-1:0]      killed_q;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;

   logic kill_req;
   logic head_live;
   logic head_killed;
   logic buf_valid;
   logic bypass;
   logic push;
   logic pop;
   logic discard;

   assign kill_req    = commit_valid && commit_kill;
   assign head_live   = valid_q[head_q];
   assign head_killed = killed_q[head_q];
   assign buf_valid   = head_live && !head_killed;

   // Readiness depends on occupancy only; a full buffer never accepts, even when popping.
   assign in_ready = (count_q < CW'(DEPTH)) && !flush;

`ifdef RVFPM_RESBUF_BYPASS_EN
   assign bypass = (count_q == '0) && in_valid && out_ready && !flush
                   && !(kill_req && (in_id == commit_id));
`else
   assign bypass = 1'b0;
`endif

   assign push    = in_valid && in_ready && !bypass;
   assign pop     = buf_valid && out_ready && !flush;
   assign discard = head_live && head_killed && !flush;

   assign out_valid = buf_valid || bypass;
   assign drop      = discard;
   assign count     = count_q;

   always_comb begin
      out_id      = id_q[head_q];
      out_data    = data_q[head_q];
      out_rd      = rd_q[head_q];
      out_ecswe   = ecswe_q[head_q];
      out_ecsdata = ecsdata_q[head_q];
      if (bypass) begin
         out_id      = in_id;
         out_data    = in_data;
         out_rd      = in_rd;
         out_ecswe   = in_ecswe;
         out_ecsdata = in_ecsdata;
      end
   end

   // pop and discard are exclusive: one needs the head live, the other killed.
   assign head_d  = head_q + PW'(pop || discard);
   assign tail_d  = tail_q + PW'(push);
   assign count_d = count_q + CW'(push) - CW'(pop) - CW'(discard);

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         killed_q <= '0;
      end else if (flush) begin
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         valid_q  <= '0;
         killed_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_req && valid_q[i] && (id_q[i] == commit_id)) begin
               killed_q[i] <= 1'b1;
            end
         end
         if (pop || discard) begin
            valid_q[head_q]  <= 1'b0;
            killed_q[head_q] <= 1'b0;
         end
         // A push never lands on the head slot being retired: that needs a full buffer.
         if (push) begin
            valid_q[tail_q]  <= 1'b1;
            killed_q[tail_q] <= kill_req && (in_id == commit_id);
         end
      end
   end

   always_ff @(posedge ck or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            id_q[i]      <= '0;
            data_q[i]    <= '0;
            rd_q[i]      <= '0;
            ecswe_q[i]   <= '0;
            ecsdata_q[i] <= '0;
         end
      end else if (push) begin
         id_q[tail_q]      <= in_id;
         data_q[tail_q]    <= in_data;
         rd_q[tail_q]      <= in_rd;
         ecswe_q[tail_q]   <= in_ecswe;
         ecsdata_q[tail_q] <= in_ecsdata;
      end
   end

endmodule

// File: tb/tb_rvfpm_result_buffer.sv
// Bench for rvfpm_result_buffer: directed scenarios plus random traffic checked
// against a queue-based model of the result buffer.
module tb_rvfpm_result_buffer;
   localparam int DEPTH = 4;

   logic        ck = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_id = '0;
   logic [31:0] in_data = '0;
   logic [4:0]  in_rd = '0;
   logic [2:0]  in_ecswe = '0;
   logic [5:0]  in_ecsdata = '0;
   logic        commit_valid = 1'b0;
   logic [3:0]  commit_id = '0;
   logic        commit_kill = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_id;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic [2:0]  out_ecswe;
   logic [5:0]  out_ecsdata;
   logic [2:0]  count;
   logic        drop;

   rvfpm_result_buffer #(.DEPTH(DEPTH), .X_ID_WIDTH(4), .FLEN(32)) dut (
      .ck(ck), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_data(in_data),
      .in_rd(in_rd), .in_ecswe(in_ecswe), .in_ecsdata(in_ecsdata),
      .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_data(out_data),
      .out_rd(out_rd), .out_ecswe(out_ecswe), .out_ecsdata(out_ecsdata),
      .count(count), .drop(drop)
   );

   always #5 ck = ~ck;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [4:0]  rd;
      logic [2:0]  ecswe;
      logic [5:0]  ecsdata;
      logic        killed;
   } ent_t;

   ent_t       mq[$];
   logic [3:0] dut_ids[$];

   logic       e_valid, e_drop, e_ready, e_byp;
   logic [2:0] e_count;
   ent_t       e_head;

   // Expected outputs for the current inputs, from the queue contents.
   task automatic model_eval;
      e_byp = 1'b0;
`ifdef RVFPM_RESBUF_BYPASS_EN
      e_byp = (mq.size() == 0) && in_valid && out_ready && !flush
              && !(commit_valid && commit_kill && in_id == commit_id);
`endif
      e_drop  = (mq.size() > 0) && mq[0].killed && !flush;
      e_valid = e_byp || ((mq.size() > 0) && !mq[0].killed);
      e_ready = (mq.size() < DEPTH) && !flush;
      e_count = 3'(mq.size());
      e_head  = '0;
      if (e_byp) e_head = {in_id, in_data, in_rd, in_ecswe, in_ecsdata, 1'b0};
      else if (mq.size() > 0) e_head = mq[0];
   endtask

   task automatic model_update;
      ent_t e;
      if (flush) begin
         mq.delete();
      end else begin
         if ((mq.size() > 0) && (mq[0].killed || out_ready)) void'(mq.pop_front());
         if (commit_valid && commit_kill)
            foreach (mq[i]) if (mq[i].id == commit_id) mq[i].killed = 1'b1;
         if (in_valid && e_ready && !e_byp) begin
            e = {in_id, in_data, in_rd, in_ecswe, in_ecsdata,
                 commit_valid && commit_kill && (in_id == commit_id)};
            mq.push_back(e);
         end
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] id, input logic ordy,
                        input logic kill, input logic [3:0] cid, input logic fl);
      int r;
      in_valid   = v;
      in_id      = id;
      in_data    = $urandom;
      in_rd      = 5'($urandom_range(0, 31));
      in_ecswe   = 3'($urandom_range(0, 7));
      in_ecsdata = 6'($urandom_range(0, 63));
      out_ready  = ordy;
      flush      = fl;
      commit_id  = cid;
      if (kill) begin
         commit_valid = 1'b1;
         commit_kill  = 1'b1;
      end else begin
         // Half-asserted commits must have no effect.
         r = $urandom_range(0, 2);
         commit_valid = (r == 1);
         commit_kill  = (r == 2);
      end
   endtask

   task automatic settle;
      #2;
      model_eval();
   endtask

   task automatic tick;
      if (out_valid && out_ready && !flush) dut_ids.push_back(out_id);
      @(posedge ck);
      model_update();
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      mq.delete();
      repeat (2) @(posedge ck);
      #3;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %0b exp 0", out_valid); end
      checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset drop got %0b exp 0", drop); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset count got %0d exp 0", count); end
      checks++; if ({out_id, out_data, out_rd, out_ecswe, out_ecsdata} !== 50'd0) begin
         errors++; $display("FAIL reset out_fields got id=%0h data=%0h rd=%0h exp 0", out_id, out_data, out_rd);
      end
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %0b exp 1", in_ready); end
      @(posedge ck);
      #1;
   endtask

   task automatic test_single;
      drive(1, 3, 0, 0, 0, 0);
      in_data = 32'h3F80_0000;
      in_rd   = 5'd5;
      settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single same_cycle_valid got %0b exp 0", out_valid); end
      tick();
      drive(0, 0, 1, 0, 0, 0);
      settle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single out_valid got %0b exp 1", out_valid); end
      checks++; if (out_id !== 4'd3) begin errors++; $display("FAIL single out_id got %0d exp 3", out_id); end
      checks++; if (out_data !== 32'h3F80_0000) begin errors++; $display("FAIL single out_data got %0h exp 3f800000", out_data); end
      checks++; if (out_rd !== 5'd5) begin errors++; $display("FAIL single out_rd got %0d exp 5", out_rd); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL single count got %0d exp 1", count); end
      tick();
      drive(0, 0, 0, 0, 0, 0);
      settle();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL single count_after_pop got %0d exp 0", count); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single valid_after_pop got %0b exp 0", out_valid); end
      tick();
   endtask

   task automatic test_full;
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 4'(i), 0, 0, 4'hF, 0);
         settle();
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full in_ready[%0d] got %0b exp 1", i, in_ready); end
         checks++; if (count !== 3'(i)) begin errors++; $display("FAIL full count[%0d] got %0d exp %0d", i, count, i); end
         tick();
      end
      drive(1, 9, 0, 0, 4'hF, 0);
      settle();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full count_full got %0d exp 4", count); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full in_ready_full got %0b exp 0", in_ready); end
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         drive(0, 0, 1, 0, 4'hF, 0);
         settle();
         checks++; if (out_valid !== 1'b1 || out_id !== 4'(i)) begin
            errors++; $display("FAIL full pop[%0d] got valid=%0b id=%0d exp valid=1 id=%0d", i, out_valid, out_id, i);
         end
         checks++; if (count !== 3'(DEPTH - i)) begin errors++; $display("FAIL full pop_count[%0d] got %0d exp %0d", i, count, DEPTH - i); end
         checks++; if (in_ready !== (i > 0)) begin errors++; $display("FAIL full pop_in_ready[%0d] got %0b exp %0b", i, in_ready, i > 0); end
         tick();
      end
      drive(0, 0, 0, 0, 4'hF, 0);
      settle();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL full drained_count got %0d exp 0", count); end
      tick();
   endtask

   task automatic test_kill;
      logic       xv[3] = '{1'b1, 1'b0, 1'b1};
      logic [3:0] xi[3] = '{4'd1, 4'd0, 4'd3};
      logic       xd[3] = '{1'b0, 1'b1, 1'b0};
      logic [2:0] xc[3] = '{3'd3, 3'd2, 3'd1};
      for (int i = 1; i <= 3; i++) begin
         drive(1, 4'(i), 0, 0, 4'hF, 0);
         settle();
         tick();
      end
      drive(0, 0, 0, 1, 2, 0);
      settle();
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 0, 4'hF, 0);
         settle();
         checks++; if (out_valid !== xv[i] || (xv[i] && out_id !== xi[i])) begin
            errors++; $display("FAIL kill step%0d got valid=%0b id=%0d exp valid=%0b id=%0d", i, out_valid, out_id, xv[i], xi[i]);
         end
         checks++; if (drop !== xd[i]) begin errors++; $display("FAIL kill drop%0d got %0b exp %0b", i, drop, xd[i]); end
         checks++; if (count !== xc[i]) begin errors++; $display("FAIL kill count%0d got %0d exp %0d", i, count, xc[i]); end
         tick();
      end
   endtask

   task automatic test_push_kill;
      drive(1, 5, 1, 1, 5, 0);
      settle();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pkill bypass_valid got %0b exp 0", out_valid); end
      tick();
      drive(0, 0, 1, 0, 4'hF, 0);
      settle();
      checks++; if (out_valid !== 1'b0 || drop !== 1'b1 || count !== 3'd1) begin
         errors++; $display("FAIL pkill head got valid=%0b drop=%0b count=%0d exp 0 1 1", out_valid, drop, count);
      end
      tick();
      settle();
      checks++; if (drop !== 1'b0 || count !== 3'd0) begin
         errors++; $display("FAIL pkill after got drop=%0b count=%0d exp 0 0", drop, count);
      end
      tick();
      // Kill racing a pop of the presented head: the pop wins.
      drive(1, 7, 0, 0, 4'hF, 0);
      settle();
      tick();
      drive(0, 0, 1, 1, 7, 0);
      settle();
      checks++; if (out_valid !== 1'b1 || out_id !== 4'd7 || drop !== 1'b0) begin
         errors++; $display("FAIL race head got valid=%0b id=%0d drop=%0b exp 1 7 0", out_valid, out_id, drop);
      end
      tick();
      drive(0, 0, 1, 0, 4'hF, 0);
      settle();
      checks++; if (drop !== 1'b0 || count !== 3'd0) begin
         errors++; $display("FAIL race after got drop=%0b count=%0d exp 0 0", drop, count);
      end
      tick();
   endtask

   task automatic test_flush;
      for (int i = 10; i < 12; i++) begin
         drive(1, 4'(i), 0, 0, 4'hF, 0);
         settle();
         tick();
      end
      drive(1, 12, 0, 0, 4'hF, 1);
      settle();
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush in_ready got %0b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b1 || count !== 3'd2) begin
         errors++; $display("FAIL flush during got valid=%0b count=%0d exp 1 2", out_valid, count);
      end
      tick();
      drive(0, 0, 1, 0, 4'hF, 0);
      settle();
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL flush after got count=%0d valid=%0b exp 0 0", count, out_valid);
      end
      tick();
   endtask

   task automatic test_wrap;
      int  next_id = 0;
      int  cyc = 0;
      logic acc;
      dut_ids.delete();
      while ((next_id < 9 || mq.size() > 0) && cyc < 300) begin
         drive((next_id < 9) && ($urandom_range(0, 3) != 0), 4'(next_id),
               1'($urandom_range(0, 1)), 0, 4'hF, 0);
         settle();
         acc = in_valid && e_ready;
         checks++; if (out_valid !== e_valid || (e_valid && out_id !== e_head.id)) begin
            errors++; $display("FAIL wrap out cyc%0d got valid=%0b id=%0d exp valid=%0b id=%0d", cyc, out_valid, out_id, e_valid, e_head.id);
         end
         checks++; if (count !== e_count) begin errors++; $display("FAIL wrap count cyc%0d got %0d exp %0d", cyc, count, e_count); end
         tick();
         if (acc) next_id++;
         cyc++;
      end
      checks++; if (cyc >= 300) begin errors++; $display("FAIL wrap timeout got %0d cycles exp < 300", cyc); end
      checks++; if (dut_ids.size() != 9) begin errors++; $display("FAIL wrap delivered got %0d exp 9", dut_ids.size()); end
      foreach (dut_ids[i]) begin
         checks++; if (dut_ids[i] !== 4'(i)) begin errors++; $display("FAIL wrap order[%0d] got %0d exp %0d", i, dut_ids[i], i); end
      end
      drive(0, 0, 0, 0, 4'hF, 0);
   endtask

   task automatic test_random;
      for (int c = 0; c < 600; c++) begin
         drive($urandom_range(0, 9) < 7, 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0, 4'($urandom_range(0, 3)), $urandom_range(0, 24) == 0);
         settle();
         checks++; if (out_valid !== e_valid) begin errors++; $display("FAIL rnd out_valid c%0d got %0b exp %0b", c, out_valid, e_valid); end
         checks++; if (drop !== e_drop) begin errors++; $display("FAIL rnd drop c%0d got %0b exp %0b", c, drop, e_drop); end
         checks++; if (in_ready !== e_ready) begin errors++; $display("FAIL rnd in_ready c%0d got %0b exp %0b", c, in_ready, e_ready); end
         checks++; if (count !== e_count) begin errors++; $display("FAIL rnd count c%0d got %0d exp %0d", c, count, e_count); end
         if (e_valid) begin
            checks++;
            if ({out_id, out_data, out_rd, out_ecswe, out_ecsdata} !==
                {e_head.id, e_head.data, e_head.rd, e_head.ecswe, e_head.ecsdata}) begin
               errors++; $display("FAIL rnd fields c%0d got id=%0d data=%0h rd=%0d exp id=%0d data=%0h rd=%0d",
                                  c, out_id, out_data, out_rd, e_head.id, e_head.data, e_head.rd);
            end
         end
         tick();
      end
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 2; i++) begin
         drive(1, 4'(i), 0, 0, 4'hF, 0);
         settle();
         tick();
      end
      drive(0, 0, 0, 0, 4'hF, 0);
      #2;
      rst = 1'b0;
      #1;
      checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL areset got count=%0d valid=%0b exp 0 0", count, out_valid);
      end
      mq.delete();
      rst = 1'b1;
      @(posedge ck);
      #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_full();
      test_kill();
      test_push_kill();
      test_flush();
      test_wrap();
      test_random();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
